// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a single core load/store request into one APB
// transfer to one of NUM_SLAVES equally sized windows above BASE_ADDR, with
// byte-lane steering for stores and extraction/extension for loads.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int unsigned SLV_SIZE_LOG2 = 12,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req,
    input  logic                       i_we,
    input  logic [31:0]                i_addr,
    input  logic [31:0]                i_wdata,
    input  logic [2:0]                 i_funct3,
    output logic                       o_stall,
    output logic                       o_done,
    output logic                       o_err,
    output logic [31:0]                o_rdata,
    output logic [31:0]                o_paddr,
    output logic [NUM_SLAVES-1:0]      o_psel,
    output logic                       o_penable,
    output logic                       o_pwrite,
    output logic [31:0]                o_pwdata,
    output logic [3:0]                 o_pstrb,
    input  logic [32*NUM_SLAVES-1:0]   i_prdata,
    input  logic [NUM_SLAVES-1:0]      i_pready,
    input  logic [NUM_SLAVES-1:0]      i_pslverr
);

    localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [31:0]       offset;
    logic [31:0]       slot;
    logic              decode_err;
    logic              misalign_err;
    logic              funct3_err;
    logic              req_err;

    logic [NUM_SLAVES-1:0] psel_onehot;
    logic [31:0]       sel_prdata;
    logic              sel_pready;
    logic              sel_pslverr;

    logic [31:0]       st_wdata;
    logic [3:0]        st_strb;
    logic [31:0]       ld_shift;
    logic [31:0]       ld_data;

    // Decode the incoming request: slave slot, alignment and size/sign legality
    always_comb begin
        offset       = i_addr - BASE_ADDR;
        slot         = offset >> SLV_SIZE_LOG2;
        decode_err   = (i_addr < BASE_ADDR) || (slot >= 32'(NUM_SLAVES));
        misalign_err = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        case (i_funct3)
            3'b000, 3'b001, 3'b010: funct3_err = 1'b0;
            3'b100, 3'b101:         funct3_err = i_we;  // unsigned stores do not exist
            default:                funct3_err = 1'b1;
        endcase
        req_err = decode_err || misalign_err || funct3_err;
    end

    // One-hot select and response mux for the latched slave index
    always_comb begin
        psel_onehot = '0;
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IdxW'(k)) begin
                psel_onehot[k] = 1'b1;
                sel_prdata     = i_prdata[32*k +: 32];
                sel_pready     = i_pready[k];
                sel_pslverr    = i_pslverr[k];
            end
        end
    end

    // Store lane steering; loads drive no strobes and no data
    always_comb begin
        st_wdata = '0;
        st_strb  = '0;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    st_strb  = 4'b0001 << addr_q[1:0];
                    st_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    st_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    st_strb  = 4'b1111;
                    st_wdata = wdata_q;
                end
            endcase
        end
    end

    // Load extraction: move the addressed byte/halfword to bit 0, then extend
    always_comb begin
        ld_shift = rdata_q >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = rdata_q;
        endcase
    end

    // Next-state logic for the transfer FSM and its request registers
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        idx_d    = idx_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (i_req) begin
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    we_d     = i_we;
                    funct3_d = i_funct3;
                    idx_d    = slot[IdxW-1:0];
                    err_d    = req_err;
                    rdata_d  = '0;
                    state_d  = req_err ? StResp : StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (sel_pready) begin
                    rdata_d = sel_prdata;
                    err_d   = sel_pslverr;
                    state_d = StResp;
                end else if (cnt_q >= CntW'(TIMEOUT - 1)) begin
                    // TIMEOUT access cycles without pready: abandon the transfer
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Core-side and APB outputs decoded from the current state
    always_comb begin
        o_stall   = 1'b0;
        o_done    = 1'b0;
        o_err     = 1'b0;
        o_rdata   = '0;
        o_paddr   = '0;
        o_psel    = '0;
        o_penable = 1'b0;
        o_pwrite  = 1'b0;
        o_pwdata  = '0;
        o_pstrb   = '0;
        case (state_q)
            StIdle: o_stall = i_req & i_rst;  // held low while reset is applied
            StSetup, StAccess: begin
                o_stall   = 1'b1;
                o_psel    = psel_onehot;
                o_penable = (state_q == StAccess);
                o_paddr   = {addr_q[31:2], 2'b00};
                o_pwrite  = we_q;
                o_pwdata  = st_wdata;
                o_pstrb   = st_strb;
            end
            StResp: begin
                o_done  = 1'b1;
                o_err   = err_q;
                o_rdata = (err_q || we_q) ? 32'h0 : ld_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a reactive slave model answers APB
// transfers with configurable wait states, data, error and hang behaviour.
module tb_apb_master_bridge;

    logic         clk;
    logic         rst;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [2:0]   funct3;
    logic         o_stall, o_done, o_err;
    logic [31:0]  o_rdata, o_paddr, o_pwdata;
    logic [3:0]   o_psel, o_pstrb;
    logic         o_penable, o_pwrite;
    logic [127:0] prdata_bus;
    logic [3:0]   pready;
    logic [3:0]   slverr_cfg;

    logic [31:0]  prdata_cfg [4];
    int           wait_cfg;
    logic         hang_cfg;
    int           acc_cnt;

    int checks;
    int errors;

    // Values captured by do_txn from the APB side
    logic [3:0]   mon_psel;
    logic [31:0]  mon_paddr, mon_pwdata;
    logic [3:0]   mon_pstrb;
    logic         mon_pwrite;
    int           mon_psel_cycles, mon_pen_cycles;

    apb_master_bridge dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_we      (we),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .i_funct3  (funct3),
        .o_stall   (o_stall),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_rdata   (o_rdata),
        .o_paddr   (o_paddr),
        .o_psel    (o_psel),
        .o_penable (o_penable),
        .o_pwrite  (o_pwrite),
        .o_pwdata  (o_pwdata),
        .o_pstrb   (o_pstrb),
        .i_prdata  (prdata_bus),
        .i_pready  (pready),
        .i_pslverr (slverr_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: count access cycles, raise pready after wait_cfg of them
    always @(posedge clk) begin
        if (o_psel != 4'b0 && o_penable) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        pready = 4'b0;
        for (int k = 0; k < 4; k++)
            pready[k] = o_psel[k] & o_penable & ~hang_cfg & (acc_cnt >= wait_cfg);
    end

    always_comb prdata_bus = {prdata_cfg[3], prdata_cfg[2], prdata_cfg[1], prdata_cfg[0]};

    // Issue one request and hold it until o_done; cycle 1 is the IDLE cycle
    task automatic do_txn(input logic t_we, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic [2:0] t_f3,
                          output int cycles, output int stalls,
                          output logic [31:0] rdata, output logic err);
        int n;
        logic got;
        cycles = 0; stalls = 0; rdata = '0; err = 1'b0; got = 1'b0; n = 0;
        mon_psel = '0; mon_paddr = '0; mon_pwdata = '0; mon_pstrb = '0;
        mon_pwrite = 1'b0; mon_psel_cycles = 0; mon_pen_cycles = 0;
        @(posedge clk); #1;
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; funct3 = t_f3;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (o_stall) stalls++;
            if (o_psel != 4'b0) begin
                mon_psel   = mon_psel | o_psel;
                mon_paddr  = o_paddr;
                mon_pwdata = o_pwdata;
                mon_pstrb  = o_pstrb;
                mon_pwrite = o_pwrite;
                mon_psel_cycles++;
            end
            if (o_penable) mon_pen_cycles++;
            if (o_done) begin
                got = 1'b1; cycles = n; rdata = o_rdata; err = o_err;
            end
        end
        req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_done_seen: got no o_done, expected one within 100 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h1000_0000; wdata = 32'hFFFF_FFFF;
        funct3 = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b, expected 0", o_stall); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", o_done); end
        if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", o_err); end
        if (o_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h, expected 0", o_rdata); end
        if (o_psel !== 4'h0) begin errors++; $display("FAIL rst_psel: got %b, expected 0000", o_psel); end
        if (o_penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b, expected 0", o_penable); end
        if (o_paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h, expected 0", o_paddr); end
        if (o_pstrb !== 4'h0 || o_pwdata !== 32'h0 || o_pwrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_pwr: got strb %b data %h write %b, expected zeros", o_pstrb, o_pwdata, o_pwrite);
        end
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_store_word();
        int cyc, st; logic [31:0] rd; logic e;
        wait_cfg = 0;
        do_txn(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010, cyc, st, rd, e);
        checks += 7;
        if (cyc !== 4) begin errors++; $display("FAIL sw_latency: got %0d, expected 4", cyc); end
        if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b, expected 0", e); end
        if (mon_psel !== 4'b0010) begin errors++; $display("FAIL sw_psel: got %b, expected 0010", mon_psel); end
        if (mon_pstrb !== 4'b1111) begin errors++; $display("FAIL sw_pstrb: got %b, expected 1111", mon_pstrb); end
        if (mon_pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_pwdata: got %h, expected deadbeef", mon_pwdata); end
        if (mon_paddr !== 32'h1000_1004 || mon_pwrite !== 1'b1) begin
            errors++; $display("FAIL sw_paddr: got %h/%b, expected 10001004/1", mon_paddr, mon_pwrite);
        end
        if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h, expected 0", rd); end
    endtask

    task automatic test_load_wait();
        int cyc, st; logic [31:0] rd; logic e;
        wait_cfg = 3;
        prdata_cfg[0] = 32'h80FF_FFFF;
        do_txn(1'b0, 32'h1000_0003, 32'h1234_5678, 3'b000, cyc, st, rd, e);
        wait_cfg = 0;
        checks += 7;
        if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h, expected ffffff80", rd); end
        if (st !== 6) begin errors++; $display("FAIL lb_stall_cycles: got %0d, expected 6", st); end
        if (cyc !== 7) begin errors++; $display("FAIL lb_latency: got %0d, expected 7", cyc); end
        if (e !== 1'b0) begin errors++; $display("FAIL lb_err: got %b, expected 0", e); end
        if (mon_psel !== 4'b0001) begin errors++; $display("FAIL lb_psel: got %b, expected 0001", mon_psel); end
        if (mon_pstrb !== 4'h0 || mon_pwdata !== 32'h0) begin
            errors++; $display("FAIL lb_load_lanes: got %b/%h, expected 0000/0", mon_pstrb, mon_pwdata);
        end
        if (mon_paddr !== 32'h1000_0000) begin errors++; $display("FAIL lb_paddr: got %h, expected 10000000", mon_paddr); end
    endtask

    task automatic test_subword();
        int cyc, st; logic [31:0] rd; logic e;
        prdata_cfg[2] = 32'hBEEF_1234;
        do_txn(1'b0, 32'h1000_2002, 32'h0, 3'b101, cyc, st, rd, e);
        checks++;
        if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata: got %h, expected 0000beef", rd); end
        do_txn(1'b0, 32'h1000_2002, 32'h0, 3'b001, cyc, st, rd, e);
        checks++;
        if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata: got %h, expected ffffbeef", rd); end
        do_txn(1'b1, 32'h1000_2002, 32'h5555_ABCD, 3'b001, cyc, st, rd, e);
        checks += 2;
        if (mon_pstrb !== 4'b1100 || mon_psel !== 4'b0100) begin
            errors++; $display("FAIL sh_pstrb: got %b psel %b, expected 1100 psel 0100", mon_pstrb, mon_psel);
        end
        if (mon_pwdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_pwdata: got %h, expected abcdabcd", mon_pwdata); end
        do_txn(1'b1, 32'h1000_2001, 32'h0000_0012, 3'b000, cyc, st, rd, e);
        checks += 2;
        if (mon_pstrb !== 4'b0010) begin errors++; $display("FAIL sb_pstrb: got %b, expected 0010", mon_pstrb); end
        if (mon_pwdata !== 32'h1212_1212) begin errors++; $display("FAIL sb_pwdata: got %h, expected 12121212", mon_pwdata); end
        do_txn(1'b0, 32'h1000_2001, 32'h0, 3'b100, cyc, st, rd, e);
        checks++;
        if (rd !== 32'h0000_0012) begin errors++; $display("FAIL lbu_rdata: got %h, expected 00000012", rd); end
        do_txn(1'b0, 32'h1000_2003, 32'h0, 3'b000, cyc, st, rd, e);
        checks++;
        if (rd !== 32'hFFFF_FFBE) begin errors++; $display("FAIL lb3_rdata: got %h, expected ffffffbe", rd); end
    endtask

    task automatic test_errors();
        int cyc, st; logic [31:0] rd; logic e;
        logic [31:0] bad_addr [4];
        logic [2:0]  bad_f3 [4];
        logic        bad_we [4];
        bad_addr[0] = 32'h1000_0002; bad_f3[0] = 3'b010; bad_we[0] = 1'b0;  // misaligned word
        bad_addr[1] = 32'h1000_4000; bad_f3[1] = 3'b010; bad_we[1] = 1'b0;  // slot 4
        bad_addr[2] = 32'h1000_0001; bad_f3[2] = 3'b001; bad_we[2] = 1'b1;  // odd halfword
        bad_addr[3] = 32'h0FFF_FFFF; bad_f3[3] = 3'b000; bad_we[3] = 1'b0;  // below base
        for (int i = 0; i < 4; i++) begin
            do_txn(bad_we[i], bad_addr[i], 32'hFFFF_FFFF, bad_f3[i], cyc, st, rd, e);
            checks += 3;
            if (cyc !== 2) begin errors++; $display("FAIL err%0d_latency: got %0d, expected 2", i, cyc); end
            if (e !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL err%0d_flag: got err %b rdata %h, expected 1/0", i, e, rd);
            end
            if (mon_psel_cycles !== 0) begin
                errors++; $display("FAIL err%0d_no_apb: got %0d psel cycles, expected 0", i, mon_psel_cycles);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, st; logic [31:0] rd; logic e;
        hang_cfg = 1'b1;
        do_txn(1'b0, 32'h1000_3000, 32'h0, 3'b010, cyc, st, rd, e);
        hang_cfg = 1'b0;
        checks += 4;
        if (mon_pen_cycles !== 16) begin errors++; $display("FAIL to_access_cycles: got %0d, expected 16", mon_pen_cycles); end
        if (mon_psel !== 4'b1000 || mon_psel_cycles !== 17) begin
            errors++; $display("FAIL to_psel: got %b x%0d, expected 1000 x17", mon_psel, mon_psel_cycles);
        end
        if (cyc !== 19) begin errors++; $display("FAIL to_latency: got %0d, expected 19", cyc); end
        if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL to_err: got %b/%h, expected 1/0", e, rd); end
    endtask

    task automatic test_slverr();
        int cyc, st; logic [31:0] rd; logic e;
        slverr_cfg = 4'b0010;
        do_txn(1'b0, 32'h1000_1000, 32'h0, 3'b010, cyc, st, rd, e);
        slverr_cfg = 4'b0000;
        checks += 2;
        if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL slverr_err: got %b/%h, expected 1/0", e, rd); end
        if (cyc !== 4) begin errors++; $display("FAIL slverr_latency: got %0d, expected 4", cyc); end
        do_txn(1'b0, 32'h1000_1000, 32'h0, 3'b010, cyc, st, rd, e);
        checks++;
        if (e !== 1'b0 || rd !== prdata_cfg[1]) begin
            errors++; $display("FAIL slverr_clear: got %b/%h, expected 0/%h", e, rd, prdata_cfg[1]);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, st, n; logic [31:0] rd; logic e; logic seen;
        hang_cfg = 1'b1; seen = 1'b0; n = 0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h1000_0000; wdata = 32'h0; funct3 = 3'b010;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (o_penable) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_reach_access: got no penable, expected one"); end
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (o_psel !== 4'h0 || o_penable !== 1'b0) begin
            errors++; $display("FAIL abort_apb_idle: got %b/%b, expected 0000/0", o_psel, o_penable);
        end
        if (o_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b, expected 0", o_done); end
        if (o_stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b, expected 0", o_stall); end
        rst = 1'b1; req = 1'b0; hang_cfg = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin errors++; $display("FAIL abort_no_done_late: got %b, expected 0", o_done); end
        prdata_cfg[0] = 32'h1357_2468;
        do_txn(1'b0, 32'h1000_0000, 32'h0, 3'b010, cyc, st, rd, e);
        checks += 2;
        if (cyc !== 4 || e !== 1'b0) begin errors++; $display("FAIL abort_next_txn: got %0d/%b, expected 4/0", cyc, e); end
        if (rd !== 32'h1357_2468) begin errors++; $display("FAIL abort_next_rdata: got %h, expected 13572468", rd); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = '0;
        wait_cfg = 0; hang_cfg = 1'b0; slverr_cfg = 4'b0; acc_cnt = 0;
        for (int k = 0; k < 4; k++) prdata_cfg[k] = 32'hA5A5_0000 | 32'(k);
        test_reset();
        test_store_word();
        test_load_wait();
        test_subword();
        test_errors();
        test_timeout();
        test_slverr();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of APB slaves (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, start of the APB region.
REQ-003 SHALL have parameter SLV_SIZE_LOG2, default 12, log2 of the byte window per slave.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (>=1).
REQ-005 SHALL have port i_clk, in, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, in, 1: synchronous active-low reset.
REQ-007 SHALL have port i_req, in, 1: core load/store request, held stable until o_done.
REQ-008 SHALL have port i_we, in, 1: 1 = store, 0 = load.
REQ-009 SHALL have port i_addr, in, 32: byte address (ALU result).
REQ-010 SHALL have port i_wdata, in, 32: store data (rs2).
REQ-011 SHALL have port i_funct3, in, 3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 SHALL have port o_stall, out, 1: freezes the core PC and register write.
REQ-013 SHALL have port o_done, out, 1: one-cycle completion pulse.
REQ-014 SHALL have port o_err, out, 1: qualifies o_done; decode, misalign, PSLVERR or timeout.
REQ-015 SHALL have port o_rdata, out, 32: extended load data, valid with o_done.
REQ-016 SHALL have ports o_paddr (out, 32), o_psel (out, NUM_SLAVES, one-hot), o_penable (out, 1), o_pwrite (out, 1), o_pwdata (out, 32) and o_pstrb (out, 4).
REQ-017 SHALL have ports i_prdata (in, 32*NUM_SLAVES, slave k at [32k+31:32k]), i_pready (in, NUM_SLAVES) and i_pslverr (in, NUM_SLAVES).

Function
REQ-018 SHALL run an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-019 In IDLE with i_req=1, SHALL register the address, data, we and funct3; SHALL assert o_stall.
REQ-020 From IDLE, SHALL go to SETUP if the request is legal; otherwise SHALL go to RESP with the error flag set.
REQ-021 Slave index SHALL be (i_addr-BASE_ADDR)>>SLV_SIZE_LOG2; an index >= NUM_SLAVES or i_addr < BASE_ADDR is a decode error.
REQ-022 A halfword with addr[0]=1, or a word with addr[1:0]!=0, is a misalign error; an error SHALL produce no APB activity.
REQ-023 In SETUP, SHALL drive psel[idx]=1 and penable=0, with paddr={addr[31:2],2'b00}; SHALL go to ACCESS next cycle.
REQ-024 In ACCESS, SHALL drive penable=1 while psel and APB outputs stay stable; SHALL sample the selected slave's pready.
REQ-025 In ACCESS, on pready=1 SHALL capture prdata and pslverr, then go to RESP.
REQ-026 In ACCESS, if TIMEOUT cycles elapse with pready=0, SHALL drop psel/penable, set the error flag and go to RESP.
REQ-027 Store strobes: SB strb=4'b0001<<addr[1:0] with pwdata={4{wdata[7:0]}}; SH strb=addr[1]?1100:0011 with pwdata={2{wdata[15:0]}}; SW strb=1111.
REQ-028 Loads SHALL drive pstrb=0000 and pwdata=0.
REQ-029 Load extraction SHALL select the byte or halfword by addr[1:0] and sign- or zero-extend it per funct3.
REQ-030 In RESP, SHALL drive o_done=1, o_stall=0 and o_err=flag; o_rdata SHALL be 0 on error or store; SHALL go to IDLE next.
REQ-031 i_req SHALL be ignored in RESP; the core advances on o_done.
REQ-032 o_stall SHALL equal i_req in IDLE, 1 in SETUP and ACCESS, and 0 in RESP.
REQ-033 Outside SETUP/ACCESS, all psel and penable bits SHALL be 0.
REQ-034 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on entering ACCESS, and SHALL saturate (no wrap).
REQ-035 A legal zero-wait transfer SHALL take 4 cycles from req to done (IDLE, SETUP, ACCESS, RESP).

Reset
REQ-036 When i_rst=0 at a clock edge, SHALL enter IDLE and clear the counter and registers.
REQ-037 During reset, all outputs SHALL be 0; o_stall SHALL be 0.
REQ-038 Reset during SETUP or ACCESS SHALL abort the transfer with no o_done, deasserting psel/penable the next cycle.

Verification
REQ-039 SW to 0x1000_1004 with data 0xDEADBEEF, slave 1 pready=1 -> psel=0010, pstrb=1111, pwdata=0xDEADBEEF, o_done in cycle 4, o_err=0.
REQ-040 LB from 0x1000_0003, slave 0 returns 0x80FF_FFFF after 3 wait cycles -> o_rdata=0xFFFF_FF80 and o_stall held for 6 cycles.
REQ-041 LHU from 0x1000_2002, prdata 0xBEEF_1234 -> o_rdata=0x0000_BEEF; SH to the same address with wdata 0x5555_ABCD -> pstrb=1100, pwdata=0xABCD_ABCD.
REQ-042 LW from 0x1000_0002 or from 0x1000_4000 (NUM_SLAVES=4) -> no psel activity, o_done and o_err=1 on the 2nd cycle.
REQ-043 pready held at 0 -> psel drops after 16 ACCESS cycles, then o_err=1; separately, pslverr=1 with pready -> o_err=1.
REQ-044 i_rst=0 asserted during ACCESS -> psel=0 and penable=0 the next cycle, no o_done, and the next request completes normally.
